// File: rtl/result_stream_pkg.sv
// Shared types and constants for the result BRAM -> AXI4-Stream transmit path.
package result_stream_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        STREAM = 2'd1,
        DONE   = 2'd2
    } state_t;

    localparam int unsigned SKID_DEPTH = 2;
    localparam int unsigned BRAM_RD_LAT = 1;
    localparam int unsigned SKID_CNT_W = $clog2(SKID_DEPTH + 1);
    localparam logic [3:0]  TSTRB_ALL  = 4'hF;

endpackage

// File: rtl/axis_out_skid_buf.sv
// Two-entry shift FIFO; entry 0 is always the head so head outputs come straight from flops.
module axis_out_skid_buf
    import result_stream_pkg::*;
#(
    parameter int unsigned DATA_W = 32
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  push,
    input  logic [DATA_W-1:0]     push_data,
    input  logic                  pop,
    output logic                  head_valid,
    output logic [DATA_W-1:0]     head_data,
    output logic [SKID_CNT_W-1:0] count
);

    logic              v0, v1;
    logic [DATA_W-1:0] d0, d1;
    logic              pop_ok;

    assign pop_ok = pop & v0;

    // Entry update: push fills the first free slot, pop shifts entry 1 into the head.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            v0 <= 1'b0;
            v1 <= 1'b0;
            d0 <= '0;
            d1 <= '0;
        end else begin
            case ({push, pop_ok})
                2'b10: begin
                    if (!v0) begin
                        v0 <= 1'b1;
                        d0 <= push_data;
                    end else begin
                        v1 <= 1'b1;
                        d1 <= push_data;
                    end
                end
                2'b01: begin
                    d0 <= d1;
                    v0 <= v1;
                    v1 <= 1'b0;
                end
                2'b11: begin
                    if (v1) begin
                        d0 <= d1;
                        d1 <= push_data;
                    end else begin
                        d0 <= push_data;
                    end
                end
                default: ;
            endcase
        end
    end

    assign head_valid = v0;
    assign head_data  = d0;
    assign count      = SKID_CNT_W'(v0) + SKID_CNT_W'(v1);

endmodule

// File: rtl/result_stream_m_axis.sv
// AXI4-Stream master streaming one frame of result BRAM words to the DMA S2MM channel.
// Optional build macro RESULT_STREAM_STALL_CNT_EN adds the stall_cnt backpressure counter.
module result_stream_m_axis
    import result_stream_pkg::*;
#(
    parameter int unsigned BRAM_DEPTH           = 10,
    parameter int unsigned C_M_AXIS_TDATA_WIDTH = 32
) (
    input  logic                            M_AXIS_ACLK,
    input  logic                            M_AXIS_ARESETN,
    input  logic                            start,
    input  logic [BRAM_DEPTH:0]             len,
    output logic [BRAM_DEPTH-1:0]           res_addr,
    output logic                            res_en,
    input  logic [C_M_AXIS_TDATA_WIDTH-1:0] res_dout,
    output logic                            busy,
    output logic                            done,
    output logic                            M_AXIS_TVALID,
    output logic [C_M_AXIS_TDATA_WIDTH-1:0] M_AXIS_TDATA,
    output logic [3:0]                      M_AXIS_TSTRB,
    output logic                            M_AXIS_TLAST,
    input  logic                            M_AXIS_TREADY
`ifdef RESULT_STREAM_STALL_CNT_EN
    ,
    output logic [31:0]                     stall_cnt
`endif
);

    localparam int unsigned CNT_W = BRAM_DEPTH + 1;
    localparam int unsigned OCC_W = $clog2(SKID_DEPTH + BRAM_RD_LAT + 1);

    state_t                 state, state_nxt;
    logic [CNT_W-1:0]       len_q;
    logic [CNT_W-1:0]       rd_ptr;
    logic [CNT_W-1:0]       sent;
    logic                   rd_inflight;
    logic                   start_ok;
    logic                   hs;
    logic                   last_beat;
    logic [OCC_W-1:0]       occ;
    logic [SKID_CNT_W-1:0]  skid_cnt;

    assign start_ok  = (state == IDLE) && start && (len != '0);
    assign hs        = M_AXIS_TVALID & M_AXIS_TREADY;
    assign last_beat = M_AXIS_TVALID && (sent == (len_q - CNT_W'(1)));

    // Buffered words plus the read still in the BRAM pipe; a same-cycle pop frees one slot.
    assign occ    = OCC_W'(skid_cnt) + OCC_W'(rd_inflight);
    assign res_en = (state == STREAM) && (rd_ptr < len_q) &&
                    ((occ < OCC_W'(SKID_DEPTH)) || ((occ == OCC_W'(SKID_DEPTH)) && hs));

    assign res_addr     = rd_ptr[BRAM_DEPTH-1:0];
    assign M_AXIS_TLAST = last_beat;
    assign M_AXIS_TSTRB = TSTRB_ALL;

    // State register.
    always_ff @(posedge M_AXIS_ACLK or negedge M_AXIS_ARESETN) begin
        if (!M_AXIS_ARESETN) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Next-state and status outputs.
    always_comb begin
        state_nxt = state;
        busy      = 1'b0;
        done      = 1'b0;
        case (state)
            IDLE: begin
                if (start_ok) begin
                    state_nxt = STREAM;
                end
            end
            STREAM: begin
                busy = 1'b1;
                if (hs && last_beat) begin
                    state_nxt = DONE;
                end
            end
            DONE: begin
                done      = 1'b1;
                state_nxt = IDLE;
            end
            default: state_nxt = IDLE;
        endcase
    end

    // Frame length, read pointer, beat counter and BRAM latency tracking.
    always_ff @(posedge M_AXIS_ACLK or negedge M_AXIS_ARESETN) begin
        if (!M_AXIS_ARESETN) begin
            len_q       <= '0;
            rd_ptr      <= '0;
            sent        <= '0;
            rd_inflight <= 1'b0;
        end else begin
            rd_inflight <= res_en;
            if (start_ok) begin
                len_q  <= len;
                rd_ptr <= '0;
                sent   <= '0;
            end else begin
                if (res_en) begin
                    rd_ptr <= rd_ptr + CNT_W'(1);
                end
                if (hs) begin
                    sent <= sent + CNT_W'(1);
                end
            end
        end
    end

    axis_out_skid_buf #(
        .DATA_W (C_M_AXIS_TDATA_WIDTH)
    ) u_skid (
        .clk        (M_AXIS_ACLK),
        .rst_n      (M_AXIS_ARESETN),
        .push       (rd_inflight),
        .push_data  (res_dout),
        .pop        (M_AXIS_TREADY),
        .head_valid (M_AXIS_TVALID),
        .head_data  (M_AXIS_TDATA),
        .count      (skid_cnt)
    );

`ifdef RESULT_STREAM_STALL_CNT_EN
    logic [31:0] stall_q;

    // Saturating count of stalled cycles within the current frame.
    always_ff @(posedge M_AXIS_ACLK or negedge M_AXIS_ARESETN) begin
        if (!M_AXIS_ARESETN) begin
            stall_q <= '0;
        end else if (start_ok) begin
            stall_q <= '0;
        end else if ((state == STREAM) && M_AXIS_TVALID && !M_AXIS_TREADY && (stall_q != '1)) begin
            stall_q <= stall_q + 32'd1;
        end
    end

    assign stall_cnt = stall_q;
`endif

endmodule
